// File: rtl/game_state_controller.sv
// Game-state sequencer: resynchronises the frame clock, applies per-frame hit rules,
// and drives scores, sprite-existence flags and screen selects for the colour mapper.
module game_state_controller #(
    parameter int unsigned WIN_SCORE      = 10,
    parameter int unsigned RESPAWN_FRAMES = 60
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       start_key,
    input  logic [8:0] user1_hit_fish,
    input  logic [8:0] user2_hit_fish,
    input  logic       user1_hit_shark,
    input  logic       user2_hit_shark,
    output logic [7:0] score1,
    output logic [7:0] score2,
    output logic [8:0] fish_exist,
    output logic       user1_exist,
    output logic       user2_exist,
    output logic       shark1_exist,
    output logic       is_start,
    output logic       is_user1win,
    output logic       is_user2win
);

    typedef enum logic [1:0] {
        ST_START    = 2'd0,
        ST_PLAY     = 2'd1,
        ST_USER1WIN = 2'd2,
        ST_USER2WIN = 2'd3
    } state_t;

    localparam logic [7:0] WIN_LVL     = 8'(WIN_SCORE);
    localparam logic [7:0] RESPAWN_LVL = 8'(RESPAWN_FRAMES);

    function automatic logic [3:0] popcount9(input logic [8:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 9; i++) c = c + {3'b000, v[i]};
        return c;
    endfunction

    state_t          state, state_n;
    logic            frame_s1, frame_s2, frame_s3, tick;
    logic            start_prev, start_edge;
    logic [8:0][7:0] cnt, cnt_n;
    logic [7:0]      score1_n, score2_n;
    logic [8:0]      fish_n;
    logic            user1_n, user2_n;
    logic [8:0]      cred1, cred2, eaten;
    logic [8:0]      sum1, sum2;

    assign start_edge   = start_key & ~start_prev;
    assign is_start     = (state != ST_START);
    assign is_user1win  = (state == ST_USER1WIN);
    assign is_user2win  = (state == ST_USER2WIN);
    assign shark1_exist = (state != ST_PLAY);

    // Fish credit: only visible fish, only live users; a shared fish goes to user1.
    assign cred1 = user1_hit_fish & ~fish_exist & {9{~user1_exist}};
    assign cred2 = user2_hit_fish & ~fish_exist & {9{~user2_exist}} & ~cred1;
    assign eaten = cred1 | cred2;
    assign sum1  = {1'b0, score1} + {5'b00000, popcount9(cred1)};
    assign sum2  = {1'b0, score2} + {5'b00000, popcount9(cred2)};

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
        state_n  = state;
        score1_n = score1;
        score2_n = score2;
        fish_n   = fish_exist;
        user1_n  = user1_exist;
        user2_n  = user2_exist;
        cnt_n    = cnt;

        unique case (state)
            ST_START: begin
                if (start_edge) begin
                    state_n  = ST_PLAY;
                    score1_n = '0;
                    score2_n = '0;
                    fish_n   = '0;
                    user1_n  = 1'b0;
                    user2_n  = 1'b0;
                    cnt_n    = '0;
                end
            end
            ST_PLAY: begin
                if (tick) begin
                    score1_n = sum1[8] ? 8'hFF : sum1[7:0];
                    score2_n = sum2[8] ? 8'hFF : sum2[7:0];
                    user1_n  = user1_exist | user1_hit_shark;
                    user2_n  = user2_exist | user2_hit_shark;
                    for (int i = 0; i < 9; i++) begin
                        if (eaten[i]) begin
                            fish_n[i] = 1'b1;
                            cnt_n[i]  = RESPAWN_LVL;
                        end else if (fish_exist[i] && cnt[i] != 8'd0) begin
                            cnt_n[i] = cnt[i] - 8'd1;
                            if (cnt[i] == 8'd1) fish_n[i] = 1'b0;
                        end
                    end
                    // Game-over test sees this tick's updated scores and deaths.
                    if (score1_n >= WIN_LVL || score2_n >= WIN_LVL || (user1_n && user2_n)) begin
                        state_n = (score1_n >= score2_n) ? ST_USER1WIN : ST_USER2WIN;
                        fish_n  = '1;
                        user1_n = 1'b1;
                        user2_n = 1'b1;
                    end
                end
            end
            ST_USER1WIN, ST_USER2WIN: begin
                if (start_edge) state_n = ST_START;
            end
            default: state_n = ST_START;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= ST_START;
            frame_s1    <= 1'b0;
            frame_s2    <= 1'b0;
            frame_s3    <= 1'b0;
            tick        <= 1'b0;
            start_prev  <= 1'b0;
            score1      <= '0;
            score2      <= '0;
            fish_exist  <= '1;
            user1_exist <= 1'b1;
            user2_exist <= 1'b1;
            // NOTE: the respawn counters are a handful of flops, so clearing them on reset is cheap and keeps state defined.
            cnt         <= '0;
        end else begin
            frame_s1    <= frame_clk;
            frame_s2    <= frame_s1;
            frame_s3    <= frame_s2;
            tick        <= frame_s2 & ~frame_s3;
            start_prev  <= start_key;
            state       <= state_n;
            score1      <= score1_n;
            score2      <= score2_n;
            fish_exist  <= fish_n;
            user1_exist <= user1_n;
            user2_exist <= user2_n;
            cnt         <= cnt_n;
        end
    end

endmodule
